// File: rtl/mem_load_arbiter.sv
// rtl/mem_load_arbiter.sv - SRAM port arbiter between a running CPU and a host program loader
//
// Purpose:
//   Shares one SRAM port between the CPU and a host that streams a program
//   into memory one nibble at a time, starting at address 0. The CPU is held
//   in reset for the whole load and for RELEASE_CYCLES cycles afterwards.
//   Optional feature macro: LOADER_VERIFY_EN adds a read-back check after
//   every written nibble and reports mismatches on load_err_o.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   host_start_i                begin a load at address 0 (RUN only)
//   host_valid_i/host_data_i/host_last_i/host_ready_o
//                               host nibble stream, last marks final nibble
//   cpu_addr_i/cpu_we_n_i/cpu_wdata_i/cpu_rdata_o
//                               CPU memory port, passed through in RUN
//   cpu_reset_o                 registered reset to the CPU core
//   mem_addr_o/mem_wdata_o/mem_we_n_o/mem_rdata_i
//                               SRAM port
//   load_busy_o                 arbiter is not in RUN
//   load_count_o                nibbles written in the current/last load
//   load_err_o                  sticky read-back mismatch flag
module mem_load_arbiter #(
    parameter int unsigned RELEASE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       host_start_i,
    input  logic       host_valid_i,
    input  logic [3:0] host_data_i,
    input  logic       host_last_i,
    output logic       host_ready_o,
    input  logic [6:0] cpu_addr_i,
    input  logic       cpu_we_n_i,
    input  logic [3:0] cpu_wdata_i,
    output logic [3:0] cpu_rdata_o,
    output logic       cpu_reset_o,
    output logic [6:0] mem_addr_o,
    output logic [3:0] mem_wdata_o,
    output logic       mem_we_n_o,
    input  logic [3:0] mem_rdata_i,
    output logic       load_busy_o,
    output logic [6:0] load_count_o,
    output logic       load_err_o
);

    localparam logic [3:0] REL_INIT = 4'(RELEASE_CYCLES);

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RELEASE = 3'd4
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [3:0] rel_cnt_q;
    logic [6:0] addr_q;
    logic [6:0] count_q;
    logic [3:0] data_q;
    logic       last_q;
    logic       cpu_reset_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RELEASE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (host_start_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (host_valid_i) begin
                    state_d = ST_WRITE;
                end
            end
`ifdef LOADER_VERIFY_EN
            ST_WRITE: begin
                state_d = ST_VERIFY;
            end
            ST_VERIFY: begin
                // addr_q has already advanced; 0 here means 127 was just written
                if (last_q || (addr_q == 7'd0)) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
`else
            ST_WRITE: begin
                if (last_q || (addr_q == 7'd127)) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
`endif
            ST_RELEASE: begin
                if (rel_cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RELEASE;
            end
        endcase
    end

    // Datapath: address/count, captured nibble, release timer, CPU reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rel_cnt_q   <= REL_INIT;
            addr_q      <= 7'd0;
            count_q     <= 7'd0;
            data_q      <= 4'd0;
            last_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            // CPU reset follows the state we are entering, so it is a clean flop output
            cpu_reset_q <= (state_d != ST_RUN);

            // Timer is reloaded whenever we are outside RELEASE, so it is full on entry
            if (state_q == ST_RELEASE) begin
                rel_cnt_q <= rel_cnt_q - 4'd1;
            end else begin
                rel_cnt_q <= REL_INIT;
            end

            case (state_q)
                ST_RUN: begin
                    if (host_start_i) begin
                        addr_q  <= 7'd0;
                        count_q <= 7'd0;
                    end
                end
                ST_LOAD: begin
                    if (host_valid_i) begin
                        data_q <= host_data_i;
                        last_q <= host_last_i;
                    end
                end
                ST_WRITE: begin
                    addr_q  <= addr_q + 7'd1;
                    count_q <= count_q + 7'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LOADER_VERIFY_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state_q == ST_RUN) && host_start_i) begin
            err_q <= 1'b0;
        end else if ((state_q == ST_VERIFY) && (mem_rdata_i != data_q)) begin
            err_q <= 1'b1;
        end
    end

    assign load_err_o = err_q;
`else
    assign load_err_o = 1'b0;
`endif

    // Output logic
    always_comb begin
        host_ready_o = 1'b0;
        cpu_rdata_o  = 4'd0;
        mem_addr_o   = 7'd0;
        mem_wdata_o  = 4'd0;
        mem_we_n_o   = 1'b1;
        case (state_q)
            ST_RUN: begin
                mem_addr_o  = cpu_addr_i;
                mem_wdata_o = cpu_wdata_i;
                mem_we_n_o  = cpu_we_n_i;
                cpu_rdata_o = mem_rdata_i;
            end
            ST_LOAD: begin
                host_ready_o = 1'b1;
            end
            ST_WRITE: begin
                mem_addr_o  = addr_q;
                mem_wdata_o = data_q;
                mem_we_n_o  = 1'b0;
            end
`ifdef LOADER_VERIFY_EN
            ST_VERIFY: begin
                mem_addr_o = addr_q - 7'd1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign cpu_reset_o  = cpu_reset_q;
    assign load_busy_o  = (state_q != ST_RUN);
    assign load_count_o = count_q;

endmodule

// File: tb/tb_mem_load_arbiter.sv
// tb/tb_mem_load_arbiter.sv - directed scoreboard bench for mem_load_arbiter
module tb_mem_load_arbiter;

    localparam int RC = 2;
`ifdef LOADER_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       host_start, host_valid, host_last, host_ready;
    logic [3:0] host_data;
    logic [6:0] cpu_addr;
    logic       cpu_we_n;
    logic [3:0] cpu_wdata, cpu_rdata;
    logic       cpu_reset;
    logic [6:0] mem_addr;
    logic [3:0] mem_wdata, mem_rdata;
    logic       mem_we_n;
    logic       load_busy, load_err;
    logic [6:0] load_count;

    logic [3:0] sram [128];
    logic       force_en, corrupt;
    logic [3:0] force_val;

    int tests = 0;
    int fails = 0;
    int writes = 0;
    logic [10:0] exp_q [$];
    logic [6:0]  exp_addr = 7'd0;
    bit          hs;

    mem_load_arbiter #(.RELEASE_CYCLES(RC)) dut (
        .clk          (clk),
        .reset        (reset),
        .host_start_i (host_start),
        .host_valid_i (host_valid),
        .host_data_i  (host_data),
        .host_last_i  (host_last),
        .host_ready_o (host_ready),
        .cpu_addr_i   (cpu_addr),
        .cpu_we_n_i   (cpu_we_n),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_reset_o  (cpu_reset),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_we_n_o   (mem_we_n),
        .mem_rdata_i  (mem_rdata),
        .load_busy_o  (load_busy),
        .load_count_o (load_count),
        .load_err_o   (load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we_n === 1'b0) sram[mem_addr] <= mem_wdata;
    end

    assign mem_rdata = force_en ? force_val :
                       (corrupt && mem_addr == 7'd4) ? ~sram[mem_addr] : sram[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshake and SRAM write at negedge, return at posedge+1
    task automatic tick;
        logic [10:0] e;
        @(negedge clk);
        hs = 0;
        if (host_valid && host_ready) begin
            exp_q.push_back({exp_addr, host_data});
            exp_addr = exp_addr + 7'd1;
            hs = 1;
        end
        if (load_busy && mem_we_n === 1'b0) begin
            writes++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e[10:4]));
                chk("wr_data", 32'(mem_wdata), 32'(e[3:0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic l, output bit acc);
        host_valid = 1'b1;
        host_data  = d;
        host_last  = l;
        acc = 0;
        for (int k = 0; k < 8 && !acc; k++) begin
            tick();
            acc = hs;
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic start_load;
        host_start = 1'b1;
        exp_addr   = 7'd0;
        tick();
        host_start = 1'b0;
    endtask

    task automatic count_release(output int n);
        n = 0;
        while (cpu_reset === 1'b1 && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  n, w0, nacc;
        bit  acc;
        reset = 1'b1; host_start = 0; host_valid = 0; host_last = 0; host_data = 0;
        cpu_addr = 0; cpu_we_n = 1; cpu_wdata = 0;
        force_en = 0; force_val = 0; corrupt = 0;
        tick(); tick();

        // Reset state
        chk("rst_cpu_reset", 32'(cpu_reset), 1);
        chk("rst_busy", 32'(load_busy), 1);
        chk("rst_count", 32'(load_count), 0);
        chk("rst_err", 32'(load_err), 0);
        chk("rst_ready", 32'(host_ready), 0);
        chk("rst_we_n", 32'(mem_we_n), 1);

        reset = 1'b0;
        count_release(n);
        chk("rst_release_cycles", 32'(n), 32'(RC));
        chk("run_busy", 32'(load_busy), 0);

        // RUN pass-through
        cpu_addr = 7'h55; cpu_we_n = 0; cpu_wdata = 4'hA; force_en = 1; force_val = 4'h3;
        #1;
        chk("run_mem_addr", 32'(mem_addr), 32'h55);
        chk("run_mem_we_n", 32'(mem_we_n), 0);
        chk("run_mem_wdata", 32'(mem_wdata), 32'hA);
        chk("run_cpu_rdata", 32'(cpu_rdata), 32'h3);
        chk("run_ready", 32'(host_ready), 0);
        cpu_we_n = 1;

        // Load 1,2,3; start with simultaneous valid must not take the nibble
        w0 = writes;
        host_valid = 1; host_data = 4'hF;
        start_load();
        host_valid = 0;
        chk("ld_busy", 32'(load_busy), 1);
        chk("ld_cpu_reset", 32'(cpu_reset), 1);
        chk("ld_count0", 32'(load_count), 0);
        chk("ld_ready", 32'(host_ready), 1);
        chk("ld_no_early_push", 32'(exp_q.size()), 0);
        cpu_we_n = 0;
        #1;
        chk("ld_cpu_we_ignored", 32'(mem_we_n), 1);
        chk("ld_cpu_rdata0", 32'(cpu_rdata), 0);
        cpu_we_n = 1; force_en = 0;
        send(4'h1, 1'b0, acc);
        send(4'h2, 1'b0, acc);
        send(4'h3, 1'b1, acc);
        chk("ld_acc3", 32'(acc), 1);
        tick();
        count_release(n);
        chk("ld_release_cycles", 32'(n), 32'(RC + VER));
        chk("ld_count3", 32'(load_count), 3);
        chk("ld_writes3", 32'(writes - w0), 3);
        chk("ld_sram", 32'({sram[0], sram[1], sram[2]}), 32'h123);
        chk("ld_sb_empty", 32'(exp_q.size()), 0);

        // 130 nibbles, no last: only 128 accepted, wraps to count 0
        start_load();
        w0 = writes; nacc = 0;
        for (int i = 0; i < 130; i++) begin
            send(4'(i), 1'b0, acc);
            if (acc) nacc++;
        end
        chk("wrap_accepted", 32'(nacc), 128);
        chk("wrap_writes", 32'(writes - w0), 128);
        chk("wrap_count", 32'(load_count), 0);
        chk("wrap_busy", 32'(load_busy), 0);
        chk("wrap_sram127", 32'(sram[127]), 32'hF);
        chk("wrap_sb_empty", 32'(exp_q.size()), 0);

        // Reset after the 5th write
        start_load();
        w0 = writes;
        for (int i = 0; i < 5; i++) send(4'(i + 5), 1'b0, acc);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy", 32'(load_busy), 1);
        chk("mid_cpu_reset", 32'(cpu_reset), 1);
        chk("mid_count", 32'(load_count), 0);
        chk("mid_ready", 32'(host_ready), 0);
        host_valid = 1; host_data = 4'h9;
        for (int i = 0; i < 6; i++) tick();
        host_valid = 0;
        chk("mid_writes5", 32'(writes - w0), 5);
        chk("mid_busy_after", 32'(load_busy), 0);
        chk("mid_sb_empty", 32'(exp_q.size()), 0);

        // Read-back check with SRAM corrupting address 4
        corrupt = 1;
        start_load();
        for (int i = 0; i < 4; i++) send(4'(i + 8), 1'b0, acc);
        tick(); tick();
        chk("ver_err_before", 32'(load_err), 0);
        send(4'h7, 1'b0, acc);
        tick(); tick();
        chk("ver_err_set", 32'(load_err), 32'(VER));
        send(4'h6, 1'b1, acc);
        tick();
        count_release(n);
        chk("ver_busy", 32'(load_busy), 0);
        chk("ver_err_sticky", 32'(load_err), 32'(VER));
        chk("ver_count", 32'(load_count), 6);
        corrupt = 0;
        start_load();
        chk("ver_err_cleared", 32'(load_err), 0);
        send(4'h2, 1'b1, acc);
        tick();
        count_release(n);
        chk("ver_final_busy", 32'(load_busy), 0);
        chk("ver_sb_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_load_arbiter.md
MEM_LOAD_ARBITER -- requirements
Module: mem_load_arbiter

Interface
REQ-001 Parameter RELEASE_CYCLES, default 2, meaning cycles cpu_reset stays high after a load or reset completes (range 1..15).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 host_start  input  1  request to begin program load at address 0.
REQ-005 host_valid  input  1  host nibble valid.
REQ-006 host_data  input  4  program nibble.
REQ-007 host_last  input  1  qualifies final nibble of load.
REQ-008 host_ready  output  1  arbiter accepts nibble this cycle.
REQ-009 cpu_addr  input  7  CPU memory address.
REQ-010 cpu_we_n  input  1  CPU write enable, active-low.
REQ-011 cpu_wdata  input  4  CPU write data.
REQ-012 cpu_rdata  output  4  read data to CPU.
REQ-013 cpu_reset  output  1  registered reset to CPU core, active-high.
REQ-014 mem_addr  output  7  SRAM address.
REQ-015 mem_wdata  output  4  SRAM write data.
REQ-016 mem_we_n  output  1  SRAM write enable, active-low.
REQ-017 mem_rdata  input  4  SRAM read data.
REQ-018 load_busy  output  1  high in any state other than RUN.
REQ-019 load_count  output  7  nibbles written in current/last load.
REQ-020 load_err  output  1  sticky readback mismatch flag.

Function
REQ-021 States: RUN, LOAD, WRITE, VERIFY (macro only), RELEASE; one-hot or binary encoding free.
REQ-022 RUN: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we_n=cpu_we_n, cpu_rdata=mem_rdata, all combinational, zero latency; host_ready=0.
REQ-023 RUN + host_start: next state LOAD, cpu_reset=1 from next cycle, address counter and load_count cleared to 0, load_err cleared.
REQ-024 Non-RUN states: mem_we_n=1 unless WRITE, cpu_rdata=0, CPU inputs ignored.
REQ-025 LOAD: host_ready=1; on host_valid, capture host_data and host_last, go WRITE; otherwise stay.
REQ-026 WRITE: host_ready=0, mem_addr=counter, mem_wdata=captured nibble, mem_we_n=0 for exactly one cycle; counter and load_count increment by 1.
REQ-027 Counter wraps 127->0; write to address 127 ends load regardless of host_last (load_count then reads 0 = 128 nibbles).
REQ-028 After WRITE: captured host_last=1 or address was 127 -> RELEASE, else LOAD.
REQ-029 RELEASE: cpu_reset=1, mem bus idle (mem_we_n=1, mem_addr=0); down-counter loaded with RELEASE_CYCLES on entry, decrements each cycle, state -> RUN and cpu_reset->0 when it reaches 1.
REQ-030 host_start outside RUN ignored; host_valid outside LOAD ignored (host_ready=0).
REQ-031 host_start and host_valid in the same RUN cycle: start taken, nibble not accepted.
REQ-032 Minimum load throughput: one nibble per 2 cycles (3 with verify).

Reset
REQ-033 reset dominates all inputs, including mid-load; partially written memory is left as is.
REQ-034 Reset values: state RELEASE, release counter=RELEASE_CYCLES, cpu_reset=1, load_count=0, load_err=0, host_ready=0, mem_we_n=1.
REQ-035 CPU leaves reset RELEASE_CYCLES cycles after reset deasserts.

Configuration
REQ-036 Macro LOADER_VERIFY_EN defined: WRITE -> VERIFY; VERIFY drives mem_addr=written address, mem_we_n=1, compares mem_rdata to captured nibble, sets load_err=1 on mismatch (sticky until next host_start or reset), then applies REQ-028 transition.
REQ-037 Macro undefined: no VERIFY state, WRITE transitions per REQ-028 directly, load_err tied 0.

Verification
REQ-038 reset 1 cycle, RELEASE_CYCLES=2 -> cpu_reset high exactly 2 cycles after reset falls, then RUN, load_busy=0.
REQ-039 RUN, cpu_addr=0x55, cpu_we_n=0, cpu_wdata=0xA -> same cycle mem_addr=0x55, mem_we_n=0, mem_wdata=0xA; mem_rdata=0x3 -> cpu_rdata=0x3.
REQ-040 host_start, nibbles 1,2,3 with host_last on 3 -> SRAM addr 0..2 = 1,2,3, load_count=3, cpu_reset falls RELEASE_CYCLES after last write.
REQ-041 Load 130 nibbles, no host_last -> 128 writes, addresses 0..127, load ends after addr 127, load_count=0, nibbles 129-130 not accepted.
REQ-042 reset asserted after 5th nibble write -> state RELEASE, cpu_reset=1, no further writes, load_count=0.
REQ-043 LOADER_VERIFY_EN, SRAM model corrupts addr 4 -> load_err=1 after 5th nibble, load completes, load_err cleared by next host_start.
